// File: rtl/alu_flags_if.sv
// alu_flags_if: operand/op handshake, result and flag bundle between the register file and the ALU
interface alu_flags_if #(parameter int bits = 8);
  logic [bits-1:0] a, b, out;
  logic [2:0] op;
  logic flags_we, in_valid, in_ready, out_valid, c, z, n, v;
  modport master(output a, b, op, flags_we, in_valid, input in_ready, out, out_valid, c, z, n, v);
  modport slave(input a, b, op, flags_we, in_valid, output in_ready, out, out_valid, c, z, n, v);
endinterface

// File: rtl/alu_flags_unit.sv
// alu_flags_unit: 8-op ALU with registered result and C/Z/N/V flags; ALU_MUL_EN adds an iterative shift-add multiplier on op 111
module alu_flags_unit #(parameter int bits = 8) (
  input logic clk,
  input logic rst_n,
  alu_flags_if.slave bus
);
  localparam int msb = bits - 1;
  logic [bits-1:0] bx, res;
  logic [bits:0] sum;
  logic cin, ovf, accept, mul_op;
  // op[0] selects the inverted B operand, op[1] selects the stored carry as carry-in
  always_comb begin
    bx = bus.op[0] ? ~bus.b : bus.b;
    cin = bus.op[1] ? bus.c : bus.op[0];
    sum = {1'b0, bus.a} + {1'b0, bx} + {{bits{1'b0}}, cin};
    ovf = (bus.a[msb] == bx[msb]) && (sum[msb] != bus.a[msb]);
    res = !bus.op[2] ? sum[bits-1:0] :
          bus.op[1:0] == 2'b00 ? bus.a & bus.b :
          bus.op[1:0] == 2'b01 ? bus.a | bus.b :
          bus.op[1:0] == 2'b10 ? bus.a ^ bus.b : bus.a;
  end
  assign accept = bus.in_valid && bus.in_ready;
`ifdef ALU_MUL_EN
  localparam int cw = $clog2(bits);
  localparam logic [cw-1:0] cnt_top = cw'(bits - 1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state;
  logic [2*bits-1:0] acc, acc_nx;
  logic [bits-1:0] ma, mb;
  logic [cw-1:0] cnt;
  logic fwe;
  assign mul_op = bus.op == 3'b111;
  assign bus.in_ready = state == IDLE;
  assign acc_nx = acc + (mb[cnt] ? ({{bits{1'b0}}, ma} << cnt) : '0);
`else
  assign mul_op = 1'b0;
  assign bus.in_ready = 1'b1;
`endif
  // result/flag register; multiplier sequencing when enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out <= '0;
      bus.out_valid <= 1'b0;
      {bus.c, bus.z, bus.n, bus.v} <= 4'b0;
`ifdef ALU_MUL_EN
      state <= IDLE;
      acc <= '0;
      ma <= '0;
      mb <= '0;
      cnt <= '0;
      fwe <= 1'b0;
`endif
    end else begin
      bus.out_valid <= 1'b0;
      if (accept && !mul_op) begin
        bus.out <= res;
        bus.out_valid <= 1'b1;
        if (bus.flags_we) begin
          bus.c <= bus.op[2] ? bus.c : sum[bits];
          bus.z <= res == '0;
          bus.n <= res[msb];
          bus.v <= !bus.op[2] && ovf;
        end
      end
`ifdef ALU_MUL_EN
      if (state == MUL) begin
        acc <= acc_nx;
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          state <= IDLE;
          bus.out <= acc_nx[bits-1:0];
          bus.out_valid <= 1'b1;
          if (fwe) begin
            bus.c <= |acc_nx[2*bits-1:bits];
            bus.z <= acc_nx[bits-1:0] == '0;
            bus.n <= acc_nx[msb];
            bus.v <= 1'b0;
          end
        end
      end else if (accept && mul_op) begin
        state <= MUL;
        acc <= '0;
        ma <= bus.a;
        mb <= bus.b;
        cnt <= cnt_top;
        fwe <= bus.flags_we;
      end
`endif
    end
endmodule
